mux_rr_xx: RTL and testbench
============================

Name: mux_rr_xx

Overview:
- Parametrised N:1 data selector with per-channel valid/ready handshake.
- Has two selection modes: round-robin arbitration, or fixed select from a port.
- Output is registered in a single-entry pipeline stage with a sticky valid.
- Sits in rtl/macro as the general-purpose successor to the combinational 4:1 selectors. Datapath blocks use it to merge several producers onto one consumer without losing or duplicating words.

Parameters:
- WIDTH, 1, data width per channel in bits.
- NCH, 4, number of input channels; legal range is 2..16.
- SELW, 2, width of the select/index fields; must satisfy 2^SELW >= NCH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = round-robin arbitration, 1 = fixed select from sel.
- sel  input  SELW  channel index used when mode=1.
- in_vld  input  NCH  per-channel valid; bit i belongs to channel i.
- in_dat  input  NCH*WIDTH  channel i data occupies bits [i*WIDTH +: WIDTH].
- in_rdy  output  NCH  per-channel ready; one-hot or all-zero.
- out_vld  output  1  output register holds a word.
- out_dat  output  WIDTH  registered data.
- out_sel  output  SELW  index of the channel that supplied out_dat.
- out_rdy  input  1  consumer accepts the word when out_vld & out_rdy.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - out_vld=0, out_dat=0, out_sel=0, round-robin pointer ptr=0.
  - in_rdy=0 in the same cycle rst is high (in_rdy is gated by !rst).
- Reset mid-operation: any held word is discarded and is not presented again. Input transfers offered during the reset cycle do not occur.
- Load enable: ld = !rst & (!out_vld | out_rdy). The register accepts a new word when it is empty or is being drained in the same cycle. This gives full throughput: one word per cycle when out_rdy stays high.
- Grant, round-robin (mode=0):
  - Scan channels ptr, ptr+1, ... NCH-1, 0, ... ptr-1 (wrapping mod NCH).
  - The first channel with in_vld=1 wins; g denotes its index.
  - If no channel is valid, there is no grant.
- Grant, fixed (mode=1):
  - g=sel when in_vld[sel]=1.
  - No grant when in_vld[sel]=0 or sel >= NCH.
- Handshake: in_rdy[g]=1 only when a grant exists and ld=1; all other bits are 0. A transfer from channel g occurs when in_vld[g] & in_rdy[g].
- On a transfer:
  - out_dat <= in_dat[g], out_sel <= g, out_vld <= 1.
  - In mode 0 only: ptr <= (g+1) mod NCH, wrapping from NCH-1 to 0.
  - In mode 1, ptr is unchanged.
- If ld=1 and there is no grant:
  - out_vld <= 0 when out_rdy drained the word; otherwise out_vld stays 0.
  - out_dat and out_sel hold their last values.
- If out_vld=1 and out_rdy=0:
  - out_vld, out_dat and out_sel hold.
  - in_rdy is all-zero.
  - Inputs must hold data until they see in_rdy.
- Latency: one cycle from the input transfer edge to out_vld=1.
- Combinational paths: in_rdy depends on in_vld, mode, sel and out_rdy. There is no path from in_dat to any output.
- Mode or sel changes take effect at the next grant decision. A held output word is not affected.
- NCH not a power of 2: ptr and index arithmetic wrap at NCH, not at 2^SELW.

Test Plan:
- Reset mid-stream:
  - Stimulus: NCH=4, load channel 2 (out_vld=1, out_rdy=0), then assert rst for one cycle.
  - Required: next cycle out_vld=0, out_sel=0, out_dat=0, in_rdy=0000 during reset. The channel 2 word is never output.
- Round-robin fairness:
  - Stimulus: mode=0, in_vld=1111 held, out_rdy=1, channel i data = 0xA0+i.
  - Required: out_sel sequence 0,1,2,3,0,1… and out_dat 0xA0,0xA1,0xA2,0xA3,0xA0…, one word per cycle with no bubbles.
- Sparse requests and pointer skip:
  - Stimulus: mode=0, ptr=1, in_vld=1001.
  - Required: channel 3 is granted first (ptr→0), then channel 0 (ptr→1).
- Backpressure:
  - Stimulus: out_vld=1, out_rdy=0 for 5 cycles with in_vld=1111.
  - Required: out_dat, out_sel and out_vld are stable, and in_rdy=0000 throughout. On the cycle out_rdy returns to 1, exactly one new word loads.
- Fixed mode:
  - Stimulus: mode=1, sel=2, in_vld=1111.
  - Required: only channel 2 is served and ptr is unchanged.
  - Stimulus: sel=2, in_vld=1011. Required: in_rdy=0000, and out_vld drops after the held word drains.
- Non-power-of-two and out-of-range select:
  - Stimulus: NCH=3, SELW=2, mode=0, all valid.
  - Required: grant sequence 0,1,2,0. Then with mode=1 and sel=3, no grant and in_rdy=000.

Source files
------------

// File: rtl/mux_rr_xx_if.sv
// mux_rr_xx_if: channel handshake and registered output bus of the N:1 selector
interface mux_rr_xx_if #(
  parameter int WIDTH = 1,
  parameter int NCH = 4,
  parameter int SELW = 2
);
  logic mode;
  logic [SELW-1:0] sel;
  logic [NCH-1:0] in_vld;
  logic [NCH*WIDTH-1:0] in_dat;
  logic [NCH-1:0] in_rdy;
  logic out_vld;
  logic [WIDTH-1:0] out_dat;
  logic [SELW-1:0] out_sel;
  logic out_rdy;
  modport master (
    output mode, sel, in_vld, in_dat, out_rdy,
    input in_rdy, out_vld, out_dat, out_sel
  );
  modport slave (
    input mode, sel, in_vld, in_dat, out_rdy,
    output in_rdy, out_vld, out_dat, out_sel
  );
endinterface

// File: rtl/mux_rr_xx.sv
// mux_rr_xx: N:1 valid/ready selector, round-robin or fixed select, registered output
module mux_rr_xx #(
  parameter int WIDTH = 1,
  parameter int NCH = 4,
  parameter int SELW = 2
) (
  input logic clk,
  input logic rst,
  mux_rr_xx_if.slave bus
);
  logic [SELW-1:0] ptr, rr_g, g;
  logic [2**SELW-1:0] vld_pad;
  logic rr_hit, hit, ld;
  logic [WIDTH-1:0] dat;
  // zero-padded valids make sel >= NCH an automatic no-grant
  always_comb begin
    vld_pad = '0;
    vld_pad[NCH-1:0] = bus.in_vld;
    rr_hit = 1'b0;
    rr_g = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (vld_pad[SELW'((int'(ptr) + k) % NCH)]) begin
        rr_hit = 1'b1;
        rr_g = SELW'((int'(ptr) + k) % NCH);
      end
  end
  assign ld = !rst && (!bus.out_vld || bus.out_rdy);
  assign hit = bus.mode ? vld_pad[bus.sel] : rr_hit;
  assign g = bus.mode ? bus.sel : rr_g;
  assign bus.in_rdy = (hit && ld) ? (NCH'(1) << g) : '0;
  always_comb begin
    dat = '0;
    for (int i = 0; i < NCH; i++)
      if (g == SELW'(i)) dat = bus.in_dat[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_vld <= 1'b0;
      bus.out_dat <= '0;
      bus.out_sel <= '0;
      ptr <= '0;
    end else if (ld) begin
      bus.out_vld <= hit;
      if (hit) begin
        bus.out_dat <= dat;
        bus.out_sel <= g;
        if (!bus.mode) ptr <= (int'(g) == NCH - 1) ? '0 : g + SELW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_xx.sv
// tb_mux_rr_xx: directed self-checking bench for mux_rr_xx with NCH=4 and NCH=3
module tb_mux_rr_xx;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  mux_rr_xx_if #(.WIDTH(8), .NCH(4), .SELW(2)) b4 ();
  mux_rr_xx_if #(.WIDTH(8), .NCH(3), .SELW(2)) b3 ();
  mux_rr_xx #(.WIDTH(8), .NCH(4), .SELW(2)) u4 (.clk(clk), .rst(rst), .bus(b4));
  mux_rr_xx #(.WIDTH(8), .NCH(3), .SELW(2)) u3 (.clk(clk), .rst(rst), .bus(b3));
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #1;
  endtask
  task test_reset;
    b4.mode = 1'b1;
    b4.sel = 2'd2;
    b4.in_vld = 4'b0100;
    b4.out_rdy = 1'b0;
    tick;
    total++;
    if (b4.out_vld !== 1'b1 || b4.out_sel !== 2'd2 || b4.out_dat !== 8'hA2) begin
      bad++;
      $display("FAIL rst_load: vld=%b sel=%0d dat=%h want 1 2 a2", b4.out_vld, b4.out_sel, b4.out_dat);
    end
    b4.in_vld = 4'b1111;
    rst = 1'b1;
    #1;
    total++;
    if (b4.in_rdy !== 4'b0000) begin
      bad++;
      $display("FAIL rst_rdy: in_rdy=%b want 0000", b4.in_rdy);
    end
    tick;
    total++;
    if (b4.out_vld !== 1'b0 || b4.out_sel !== 2'd0 || b4.out_dat !== 8'h00) begin
      bad++;
      $display("FAIL rst_out: vld=%b sel=%0d dat=%h want 0 0 00", b4.out_vld, b4.out_sel, b4.out_dat);
    end
    rst = 1'b0;
    b4.in_vld = 4'b0000;
    b4.out_rdy = 1'b1;
    tick;
    total++;
    if (b4.out_vld !== 1'b0) begin
      bad++;
      $display("FAIL rst_discard: out_vld=%b want 0", b4.out_vld);
    end
  endtask
  task test_rr_fairness;
    logic [3:0] e;
    b4.mode = 1'b0;
    b4.in_vld = 4'b1111;
    b4.out_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e = 4'b0001 << (k % 4);
      #1;
      total++;
      if (b4.in_rdy !== e) begin
        bad++;
        $display("FAIL rr_rdy[%0d]: in_rdy=%b want %b", k, b4.in_rdy, e);
      end
      tick;
      total++;
      if (b4.out_vld !== 1'b1 || b4.out_sel !== 2'(k % 4) || b4.out_dat !== 8'(8'hA0 + k % 4)) begin
        bad++;
        $display("FAIL rr_out[%0d]: vld=%b sel=%0d dat=%h want 1 %0d %h", k, b4.out_vld, b4.out_sel, b4.out_dat, k % 4, 8'hA0 + k % 4);
      end
    end
  endtask
  task test_sparse;
    b4.in_vld = 4'b0001;
    tick;
    b4.in_vld = 4'b1001;
    #1;
    total++;
    if (b4.in_rdy !== 4'b1000) begin
      bad++;
      $display("FAIL sparse_rdy3: in_rdy=%b want 1000", b4.in_rdy);
    end
    tick;
    total++;
    if (b4.out_sel !== 2'd3 || b4.out_dat !== 8'hA3) begin
      bad++;
      $display("FAIL sparse_out3: sel=%0d dat=%h want 3 a3", b4.out_sel, b4.out_dat);
    end
    total++;
    if (b4.in_rdy !== 4'b0001) begin
      bad++;
      $display("FAIL sparse_rdy0: in_rdy=%b want 0001", b4.in_rdy);
    end
    tick;
    total++;
    if (b4.out_sel !== 2'd0 || b4.out_dat !== 8'hA0) begin
      bad++;
      $display("FAIL sparse_out0: sel=%0d dat=%h want 0 a0", b4.out_sel, b4.out_dat);
    end
    b4.in_vld = 4'b0000;
    tick;
    total++;
    if (b4.out_vld !== 1'b0 || b4.out_sel !== 2'd0) begin
      bad++;
      $display("FAIL sparse_drain: vld=%b sel=%0d want 0 0", b4.out_vld, b4.out_sel);
    end
  endtask
  task test_backpressure;
    b4.in_vld = 4'b1111;
    b4.out_rdy = 1'b0;
    #1;
    total++;
    if (b4.in_rdy !== 4'b0010) begin
      bad++;
      $display("FAIL bp_first_rdy: in_rdy=%b want 0010", b4.in_rdy);
    end
    tick;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (b4.in_rdy !== 4'b0000) begin
        bad++;
        $display("FAIL bp_rdy[%0d]: in_rdy=%b want 0000", k, b4.in_rdy);
      end
      tick;
      total++;
      if (b4.out_vld !== 1'b1 || b4.out_sel !== 2'd1 || b4.out_dat !== 8'hA1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: vld=%b sel=%0d dat=%h want 1 1 a1", k, b4.out_vld, b4.out_sel, b4.out_dat);
      end
    end
    b4.out_rdy = 1'b1;
    #1;
    total++;
    if (b4.in_rdy !== 4'b0100) begin
      bad++;
      $display("FAIL bp_release_rdy: in_rdy=%b want 0100", b4.in_rdy);
    end
    tick;
    b4.out_rdy = 1'b0;
    tick;
    total++;
    if (b4.out_vld !== 1'b1 || b4.out_sel !== 2'd2 || b4.out_dat !== 8'hA2) begin
      bad++;
      $display("FAIL bp_one_word: vld=%b sel=%0d dat=%h want 1 2 a2", b4.out_vld, b4.out_sel, b4.out_dat);
    end
  endtask
  task test_fixed;
    b4.mode = 1'b1;
    b4.sel = 2'd2;
    b4.out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (b4.in_rdy !== 4'b0100) begin
        bad++;
        $display("FAIL fix_rdy[%0d]: in_rdy=%b want 0100", k, b4.in_rdy);
      end
      tick;
      total++;
      if (b4.out_vld !== 1'b1 || b4.out_sel !== 2'd2 || b4.out_dat !== 8'hA2) begin
        bad++;
        $display("FAIL fix_out[%0d]: vld=%b sel=%0d dat=%h want 1 2 a2", k, b4.out_vld, b4.out_sel, b4.out_dat);
      end
    end
    b4.in_vld = 4'b1011;
    #1;
    total++;
    if (b4.in_rdy !== 4'b0000) begin
      bad++;
      $display("FAIL fix_novld_rdy: in_rdy=%b want 0000", b4.in_rdy);
    end
    tick;
    total++;
    if (b4.out_vld !== 1'b0 || b4.out_sel !== 2'd2) begin
      bad++;
      $display("FAIL fix_drain: vld=%b sel=%0d want 0 2", b4.out_vld, b4.out_sel);
    end
    b4.mode = 1'b0;
    b4.in_vld = 4'b1111;
    #1;
    total++;
    if (b4.in_rdy !== 4'b1000) begin
      bad++;
      $display("FAIL fix_ptr_kept: in_rdy=%b want 1000", b4.in_rdy);
    end
  endtask
  task test_npot;
    logic [2:0] e;
    b3.mode = 1'b0;
    b3.in_vld = 3'b111;
    b3.out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = 3'b001 << (k % 3);
      #1;
      total++;
      if (b3.in_rdy !== e) begin
        bad++;
        $display("FAIL npot_rdy[%0d]: in_rdy=%b want %b", k, b3.in_rdy, e);
      end
      tick;
      total++;
      if (b3.out_vld !== 1'b1 || b3.out_sel !== 2'(k % 3) || b3.out_dat !== 8'(8'hB0 + k % 3)) begin
        bad++;
        $display("FAIL npot_out[%0d]: vld=%b sel=%0d dat=%h want 1 %0d %h", k, b3.out_vld, b3.out_sel, b3.out_dat, k % 3, 8'hB0 + k % 3);
      end
    end
    b3.mode = 1'b1;
    b3.sel = 2'd3;
    #1;
    total++;
    if (b3.in_rdy !== 3'b000) begin
      bad++;
      $display("FAIL npot_sel3_rdy: in_rdy=%b want 000", b3.in_rdy);
    end
    tick;
    total++;
    if (b3.out_vld !== 1'b0 || b3.out_sel !== 2'd0) begin
      bad++;
      $display("FAIL npot_sel3_out: vld=%b sel=%0d want 0 0", b3.out_vld, b3.out_sel);
    end
  endtask
  initial begin
    rst = 1'b1;
    b4.mode = 1'b0;
    b4.sel = '0;
    b4.in_vld = '0;
    b4.in_dat = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b4.out_rdy = 1'b1;
    b3.mode = 1'b0;
    b3.sel = '0;
    b3.in_vld = '0;
    b3.in_dat = {8'hB2, 8'hB1, 8'hB0};
    b3.out_rdy = 1'b1;
    tick;
    tick;
    total++;
    if (b4.out_vld !== 1'b0 || b4.out_sel !== 2'd0 || b4.out_dat !== 8'h00 || b4.in_rdy !== 4'b0000) begin
      bad++;
      $display("FAIL init_reset: vld=%b sel=%0d dat=%h rdy=%b want 0 0 00 0000", b4.out_vld, b4.out_sel, b4.out_dat, b4.in_rdy);
    end
    rst = 1'b0;
    test_reset;
    test_rr_fairness;
    test_sparse;
    test_backpressure;
    test_fixed;
    test_npot;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
